// File: rtl/multi_ctrl_fsm.sv
// Multicycle MIPS control unit with its own state register.
// Decodes the base and extended opcode sets, optionally stalls memory
// states on a ready handshake with a timeout, and traps illegal opcodes.
module multi_ctrl_fsm #(
    parameter int EXT_ISA      = 1,
    parameter int MEM_WAIT_EN  = 0,
    parameter int WAIT_LIMIT   = 15,
    parameter int ILLEGAL_HALT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_to_reg,
    output logic [1:0] reg_dst,
    output logic       wd_pc,
    output logic       iord,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       pc_write,
    output logic       branch,
    output logic       branch_ne,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT_C = CW'(WAIT_LIMIT);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic EXT_C      = (EXT_ISA != 0);
    localparam logic WAIT_EN_C  = (MEM_WAIT_EN != 0);
    localparam logic LIMIT_EN_C = (WAIT_LIMIT > 0);
    localparam logic HALT_C     = (ILLEGAL_HALT != 0);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP   = 4'd11,
        S_JAL    = 4'd12, S_ERR    = 4'd15
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          run_r;
    logic          illegal_r;
    logic          bus_err_r;
    logic [CW-1:0] wait_cnt_r;
    logic [CW-1:0] wait_cnt_nxt_s;
    logic          wait_state_s;
    logic          mem_done_s;
    logic          timeout_s;
    logic          set_illegal_s;
    logic          set_bus_err_s;

    // Dispatch target after DECODE; extended opcodes are illegal without EXT_ISA.
    function automatic state_t decode_next(input logic [5:0] opc);
        state_t s;
        case (opc)
            OP_RTYPE:                  s = S_EXEC;
            OP_LW, OP_SW:              s = S_MEMADR;
            OP_BEQ:                    s = S_BRANCH;
            OP_ADDI:                   s = S_IMMEX;
            OP_J:                      s = S_JUMP;
            OP_BNE:                    s = EXT_C ? S_BRANCH : S_ERR;
            OP_ANDI, OP_ORI, OP_SLTI:  s = EXT_C ? S_IMMEX : S_ERR;
            OP_JAL:                    s = EXT_C ? S_JAL : S_ERR;
            default:                   s = S_ERR;
        endcase
        return s;
    endfunction

    // ALU operation for immediate arithmetic/logic instructions.
    function automatic logic [2:0] imm_alu_op(input logic [5:0] opc);
        logic [2:0] a;
        case (opc)
            OP_ANDI: a = 3'b011;
            OP_ORI:  a = 3'b100;
            OP_SLTI: a = 3'b101;
            default: a = 3'b000;
        endcase
        return a;
    endfunction

    // Memory handshake: completion, timeout detection and wait counter update.
    always_comb begin
        wait_state_s = WAIT_EN_C && run_r &&
                       ((state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR));
        mem_done_s   = !WAIT_EN_C || mem_ready;
        timeout_s    = wait_state_s && LIMIT_EN_C && !mem_ready && (wait_cnt_r == LIMIT_C);
        if (wait_state_s && LIMIT_EN_C && !mem_ready && (wait_cnt_r != LIMIT_C)) begin
            wait_cnt_nxt_s = wait_cnt_r + ONE_C;
        end else begin
            wait_cnt_nxt_s = {CW{1'b0}};
        end
    end

    // Next-state and datapath control decode from state and opcode.
    always_comb begin
        mem_to_reg    = 1'b0;
        reg_dst       = 2'b00;
        wd_pc         = 1'b0;
        iord          = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        imm_zext      = 1'b0;
        pc_src        = 2'b00;
        alu_op        = 3'b000;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        branch_ne     = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        set_illegal_s = 1'b0;
        set_bus_err_s = 1'b0;
        state_nxt_s   = state_r;
        // run_r holds everything idle until the first edge after reset release.
        if (run_r) begin
            case (state_r)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_done_s) begin
                        ir_write    = 1'b1;
                        pc_write    = 1'b1;
                        state_nxt_s = S_DECODE;
                    end else if (timeout_s) begin
                        set_bus_err_s = 1'b1;
                        state_nxt_s   = S_ERR;
                    end else begin
                        state_nxt_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    alu_src_b     = 2'b11;
                    state_nxt_s   = decode_next(op);
                    set_illegal_s = (decode_next(op) == S_ERR);
                end
                S_MEMADR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    state_nxt_s = (op == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                    if (mem_done_s) begin
                        state_nxt_s = S_MEMWB;
                    end else if (timeout_s) begin
                        set_bus_err_s = 1'b1;
                        state_nxt_s   = S_ERR;
                    end else begin
                        state_nxt_s = S_MEMRD;
                    end
                end
                S_MEMWB: begin
                    mem_to_reg  = 1'b1;
                    reg_write   = 1'b1;
                    instr_done  = 1'b1;
                    state_nxt_s = S_FETCH;
                end
                S_MEMWR: begin
                    iord = 1'b1;
                    if (mem_done_s) begin
                        mem_write   = 1'b1;
                        instr_done  = 1'b1;
                        state_nxt_s = S_FETCH;
                    end else if (timeout_s) begin
                        set_bus_err_s = 1'b1;
                        state_nxt_s   = S_ERR;
                    end else begin
                        state_nxt_s = S_MEMWR;
                    end
                end
                S_EXEC: begin
                    alu_src_a   = 1'b1;
                    alu_op      = 3'b010;
                    state_nxt_s = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_dst     = 2'b01;
                    reg_write   = 1'b1;
                    instr_done  = 1'b1;
                    state_nxt_s = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_op      = 3'b001;
                    pc_src      = 2'b01;
                    branch      = (op == OP_BEQ);
                    branch_ne   = (op == OP_BNE);
                    instr_done  = 1'b1;
                    state_nxt_s = S_FETCH;
                end
                S_IMMEX: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_op      = imm_alu_op(op);
                    imm_zext    = (op == OP_ANDI) || (op == OP_ORI);
                    state_nxt_s = S_IMMWB;
                end
                S_IMMWB: begin
                    alu_op      = imm_alu_op(op);
                    imm_zext    = (op == OP_ANDI) || (op == OP_ORI);
                    reg_write   = 1'b1;
                    instr_done  = 1'b1;
                    state_nxt_s = S_FETCH;
                end
                S_JUMP: begin
                    pc_src      = 2'b10;
                    pc_write    = 1'b1;
                    instr_done  = 1'b1;
                    state_nxt_s = S_FETCH;
                end
                S_JAL: begin
                    reg_dst     = 2'b10;
                    wd_pc       = 1'b1;
                    reg_write   = 1'b1;
                    pc_src      = 2'b10;
                    pc_write    = 1'b1;
                    instr_done  = 1'b1;
                    state_nxt_s = S_FETCH;
                end
                S_ERR: begin
                    if (HALT_C) begin
                        state_nxt_s = S_ERR;
                    end else begin
                        instr_done  = 1'b1;
                        state_nxt_s = S_FETCH;
                    end
                end
                default: begin
                    state_nxt_s = S_ERR;
                end
            endcase
        end else begin
            state_nxt_s = S_FETCH;
        end
    end

    // State register, sticky error flags and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_FETCH;
            run_r      <= 1'b0;
            illegal_r  <= 1'b0;
            bus_err_r  <= 1'b0;
            wait_cnt_r <= {CW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            run_r      <= 1'b1;
            illegal_r  <= illegal_r | set_illegal_s;
            bus_err_r  <= bus_err_r | set_bus_err_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    assign illegal = illegal_r;
    assign bus_err = bus_err_r;
    assign state   = state_r;

endmodule
